// File: rtl/app_mul_sequencer_if.sv
// Request, shared-multiplier and result bundle for the vector multiply sequencer.
// The master side is the environment; the slave side is the sequencer.
interface app_mul_sequencer_if #(
  parameter int unsigned NUM_LANES = 16
);
  logic                      start_valid;
  logic                      start_ready;
  logic                      op_signed;
  logic [NUM_LANES-1:0]      op_mask;
  logic [NUM_LANES*16-1:0]   op_multiplicant;
  logic [NUM_LANES*16-1:0]   op_multiplier;

  logic                      mul_sign;
  logic [15:0]               mul_multiplicant;
  logic [15:0]               mul_multiplier;
  logic [31:0]               mul_product;

  logic                      result_valid;
  logic                      result_ready;
  logic [NUM_LANES*32-1:0]   result_product;

  logic                      flush;
  logic [31:0]               ops_completed;

  modport master (
    output start_valid, op_signed, op_mask, op_multiplicant, op_multiplier,
    output mul_product, result_ready, flush,
    input  start_ready, mul_sign, mul_multiplicant, mul_multiplier,
    input  result_valid, result_product, ops_completed
  );

  modport slave (
    input  start_valid, op_signed, op_mask, op_multiplicant, op_multiplier,
    input  mul_product, result_ready, flush,
    output start_ready, mul_sign, mul_multiplicant, mul_multiplier,
    output result_valid, result_product, ops_completed
  );
endinterface

// File: rtl/app_mul_sequencer.sv
// Serialises a masked 16-bit vector multiply onto one shared scalar multiplier,
// one enabled lane per cycle, and holds the product vector until consumed.
module app_mul_sequencer #(
  parameter int unsigned NUM_LANES = 16
) (
  input  logic                clk,
  input  logic                reset,
  app_mul_sequencer_if.slave  bus
);

  localparam int unsigned LANE_W = 16;
  localparam int unsigned PROD_W = 32;
  localparam int unsigned PTR_W  = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                      state_q, state_d;
  logic [PTR_W-1:0]            ptr_q, ptr_d;

  logic                        signed_q;
  logic [NUM_LANES-1:0]        mask_q;
  logic [NUM_LANES*LANE_W-1:0] mcand_q;
  logic [NUM_LANES*LANE_W-1:0] mplier_q;
  logic [NUM_LANES*PROD_W-1:0] result_q;
  logic [31:0]                 ops_q;

  logic                        start_ready_q, start_ready_d;
  logic                        result_valid_q, result_valid_d;
  logic                        mul_sign_q, mul_sign_d;
  logic [LANE_W-1:0]           mul_mcand_q, mul_mcand_d;
  logic [LANE_W-1:0]           mul_mplier_q, mul_mplier_d;

  logic                        accept;
  logic                        handshake;
  logic [PTR_W:0]              first_hit;
  logic [PTR_W:0]              next_hit;

  // Lowest set mask bit at index >= from; MSB of the result flags "found".
  function automatic logic [PTR_W:0] first_set(input logic [NUM_LANES-1:0] mask,
                                               input int from);
    logic [PTR_W:0] r;
    r = '0;
    for (int i = int'(NUM_LANES) - 1; i >= 0; i--) begin
      if (mask[i] && (i >= from)) r = {1'b1, PTR_W'(i)};
    end
    return r;
  endfunction

  assign accept    = (state_q == IDLE) && bus.start_valid && !bus.flush;
  assign handshake = (state_q == DONE) && bus.result_ready && !bus.flush;
  assign first_hit = first_set(bus.op_mask, 0);
  assign next_hit  = first_set(mask_q, int'(ptr_q) + 1);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next-state logic; flush overrides every transition
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (bus.flush) begin
      state_d = IDLE;
      ptr_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start_valid) begin
            if (first_hit[PTR_W]) begin
              state_d = BUSY;
              ptr_d   = first_hit[PTR_W-1:0];
            end else begin
              state_d = DONE;
              ptr_d   = '0;
            end
          end
        end
        BUSY: begin
          if (next_hit[PTR_W]) begin
            ptr_d = next_hit[PTR_W-1:0];
          end else begin
            state_d = DONE;
          end
        end
        DONE: begin
          if (bus.result_ready) state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          ptr_d   = '0;
        end
      endcase
    end
  end

  // Next values of the registered outputs; operands come from the request
  // itself on the accepting edge because the latches are not loaded yet.
  always_comb begin
    start_ready_d  = (state_d == IDLE);
    result_valid_d = (state_d == DONE);
    mul_sign_d     = 1'b0;
    mul_mcand_d    = '0;
    mul_mplier_d   = '0;
    if (state_d == BUSY) begin
      if (state_q == IDLE) begin
        mul_sign_d   = bus.op_signed;
        mul_mcand_d  = bus.op_multiplicant[ptr_d*LANE_W +: LANE_W];
        mul_mplier_d = bus.op_multiplier[ptr_d*LANE_W +: LANE_W];
      end else begin
        mul_sign_d   = signed_q;
        mul_mcand_d  = mcand_q[ptr_d*LANE_W +: LANE_W];
        mul_mplier_d = mplier_q[ptr_d*LANE_W +: LANE_W];
      end
    end
  end

  // Output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_ready_q  <= 1'b1;
      result_valid_q <= 1'b0;
      mul_sign_q     <= 1'b0;
      mul_mcand_q    <= '0;
      mul_mplier_q   <= '0;
    end else begin
      start_ready_q  <= start_ready_d;
      result_valid_q <= result_valid_d;
      mul_sign_q     <= mul_sign_d;
      mul_mcand_q    <= mul_mcand_d;
      mul_mplier_q   <= mul_mplier_d;
    end
  end

  // Request latches, per-lane product capture and completion counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      signed_q <= 1'b0;
      mask_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      result_q <= '0;
      ops_q    <= '0;
    end else begin
      if (accept) begin
        signed_q <= bus.op_signed;
        mask_q   <= bus.op_mask;
        mcand_q  <= bus.op_multiplicant;
        mplier_q <= bus.op_multiplier;
        result_q <= '0;
      end else if ((state_q == BUSY) && !bus.flush) begin
        result_q[ptr_q*PROD_W +: PROD_W] <= bus.mul_product;
      end
      if (handshake) ops_q <= ops_q + 32'd1;
    end
  end

  assign bus.start_ready      = start_ready_q;
  assign bus.result_valid     = result_valid_q;
  assign bus.result_product   = result_q;
  assign bus.mul_sign         = mul_sign_q;
  assign bus.mul_multiplicant = mul_mcand_q;
  assign bus.mul_multiplier   = mul_mplier_q;
  assign bus.ops_completed    = ops_q;

endmodule

// File: tb/tb_app_mul_sequencer.sv
// Directed bench for app_mul_sequencer with an exact-product multiplier stub.
module tb_app_mul_sequencer;

  localparam int unsigned NL = 16;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  logic [NL*16-1:0] mcand;
  logic [NL*16-1:0] mplier;
  logic [NL*32-1:0] exp_res;
  logic [NL*32-1:0] held_res;

  app_mul_sequencer_if #(.NUM_LANES(NL)) bus ();

  app_mul_sequencer #(.NUM_LANES(NL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.mul_product = {16'b0, bus.mul_multiplicant} * {16'b0, bus.mul_multiplier};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic mul_idle(input string tag);
    checks++;
    if (bus.mul_sign !== 1'b0) begin errors++; $error("FAIL %s mul_sign=%0h", tag, bus.mul_sign); end
    checks++;
    if (bus.mul_multiplicant !== 16'd0) begin errors++; $error("FAIL %s mul_multiplicant=%0h", tag, bus.mul_multiplicant); end
    checks++;
    if (bus.mul_multiplier !== 16'd0) begin errors++; $error("FAIL %s mul_multiplier=%0h", tag, bus.mul_multiplier); end
  endtask

  // Called at a negedge where result_valid is up; completes one handshake.
  task automatic do_handshake(input string tag, input logic [31:0] exp_ops);
    bus.result_ready = 1'b1;
    @(negedge clk);
    bus.result_ready = 1'b0;
    checks++;
    if (bus.result_valid !== 1'b0) begin errors++; $error("FAIL %s hs result_valid=%0h", tag, bus.result_valid); end
    checks++;
    if (bus.start_ready !== 1'b1) begin errors++; $error("FAIL %s hs start_ready=%0h", tag, bus.start_ready); end
    checks++;
    if (bus.ops_completed !== exp_ops) begin errors++; $error("FAIL %s hs ops_completed=%0h exp=%0h", tag, bus.ops_completed, exp_ops); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.start_valid = 1'b0;
    bus.op_signed = 1'b0;
    bus.op_mask = '0;
    bus.op_multiplicant = '0;
    bus.op_multiplier = '0;
    bus.result_ready = 1'b0;
    bus.flush = 1'b0;

    // Reset state
    @(negedge clk);
    checks++;
    if (bus.start_ready !== 1'b1) begin errors++; $error("FAIL rst start_ready"); end
    checks++;
    if (bus.result_valid !== 1'b0) begin errors++; $error("FAIL rst result_valid"); end
    checks++;
    if (bus.result_product !== 512'd0) begin errors++; $error("FAIL rst result_product"); end
    checks++;
    if (bus.ops_completed !== 32'd0) begin errors++; $error("FAIL rst ops_completed"); end
    mul_idle("rst");

    // A: full mask, lane i = (i+1, 2), request on first edge after reset
    for (int i = 0; i < 16; i++) begin
      mcand[16*i +: 16]   = 16'(i + 1);
      mplier[16*i +: 16]  = 16'd2;
      exp_res[32*i +: 32] = 32'(2 * (i + 1));
    end
    @(negedge clk);
    reset = 1'b0;
    bus.start_valid = 1'b1;
    bus.op_mask = 16'hFFFF;
    bus.op_multiplicant = mcand;
    bus.op_multiplier = mplier;
    @(negedge clk);
    bus.start_valid = 1'b0;
    checks++;
    if (bus.start_ready !== 1'b0) begin errors++; $error("FAIL A start_ready busy"); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (bus.mul_multiplicant !== 16'(i + 1)) begin errors++; $error("FAIL A lane %0d multiplicant=%0h", i, bus.mul_multiplicant); end
      checks++;
      if (bus.mul_multiplier !== 16'd2) begin errors++; $error("FAIL A lane %0d multiplier=%0h", i, bus.mul_multiplier); end
      checks++;
      if (bus.result_valid !== 1'b0) begin errors++; $error("FAIL A result_valid busy lane %0d", i); end
      checks++;
      if (bus.mul_sign !== 1'b0) begin errors++; $error("FAIL A mul_sign lane %0d", i); end
      @(negedge clk);
    end
    checks++;
    if (bus.result_valid !== 1'b1) begin errors++; $error("FAIL A result_valid"); end
    checks++;
    if (bus.result_product !== exp_res) begin errors++; $error("FAIL A result_product=%0h", bus.result_product); end
    mul_idle("A done");
    do_handshake("A", 32'd1);

    // B: mask 0x8001 with a 5-cycle stall in DONE while start_valid stays high
    for (int i = 0; i < 16; i++) begin
      mcand[16*i +: 16]  = 16'd9;
      mplier[16*i +: 16] = 16'd9;
    end
    mcand[15:0]     = 16'd3;   mplier[15:0]    = 16'd7;
    mcand[255:240]  = 16'd100; mplier[255:240] = 16'd100;
    exp_res = '0;
    exp_res[31:0]    = 32'd21;
    exp_res[511:480] = 32'd10000;
    bus.start_valid = 1'b1;
    bus.op_mask = 16'h8001;
    bus.op_multiplicant = mcand;
    bus.op_multiplier = mplier;
    @(negedge clk);
    checks++;
    if (bus.mul_multiplicant !== 16'd3) begin errors++; $error("FAIL B lane0 multiplicant"); end
    checks++;
    if (bus.mul_multiplier !== 16'd7) begin errors++; $error("FAIL B lane0 multiplier"); end
    @(negedge clk);
    checks++;
    if (bus.mul_multiplicant !== 16'd100) begin errors++; $error("FAIL B lane15 multiplicant"); end
    checks++;
    if (bus.mul_multiplier !== 16'd100) begin errors++; $error("FAIL B lane15 multiplier"); end
    checks++;
    if (bus.result_valid !== 1'b0) begin errors++; $error("FAIL B result_valid busy"); end
    @(negedge clk);
    checks++;
    if (bus.result_valid !== 1'b1) begin errors++; $error("FAIL B result_valid"); end
    checks++;
    if (bus.result_product !== exp_res) begin errors++; $error("FAIL B result_product=%0h", bus.result_product); end
    held_res = bus.result_product;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (bus.result_valid !== 1'b1) begin errors++; $error("FAIL B stall result_valid"); end
      checks++;
      if (bus.start_ready !== 1'b0) begin errors++; $error("FAIL B stall start_ready"); end
      checks++;
      if (bus.result_product !== held_res) begin errors++; $error("FAIL B stall result_product"); end
      mul_idle("B stall");
    end
    do_handshake("B", 32'd2);
    bus.start_valid = 1'b0;

    // C: empty mask goes straight to DONE with cleared results
    @(negedge clk);
    bus.start_valid = 1'b1;
    bus.op_mask = 16'h0000;
    @(negedge clk);
    bus.start_valid = 1'b0;
    checks++;
    if (bus.result_valid !== 1'b1) begin errors++; $error("FAIL C result_valid"); end
    checks++;
    if (bus.result_product !== 512'd0) begin errors++; $error("FAIL C result_product"); end
    checks++;
    if (bus.start_ready !== 1'b0) begin errors++; $error("FAIL C start_ready"); end
    mul_idle("C");
    do_handshake("C", 32'd3);

    // D: signed request on lanes 1 and 2
    mcand = '0; mplier = '0;
    mcand[31:16]  = 16'd5; mplier[31:16] = 16'd6;
    mcand[47:32]  = 16'd7; mplier[47:32] = 16'd8;
    exp_res = '0;
    exp_res[63:32] = 32'd30;
    exp_res[95:64] = 32'd56;
    bus.start_valid = 1'b1;
    bus.op_signed = 1'b1;
    bus.op_mask = 16'h0006;
    bus.op_multiplicant = mcand;
    bus.op_multiplier = mplier;
    checks++;
    if (bus.mul_sign !== 1'b0) begin errors++; $error("FAIL D mul_sign idle"); end
    @(negedge clk);
    bus.start_valid = 1'b0;
    bus.op_signed = 1'b0;
    checks++;
    if (bus.mul_sign !== 1'b1) begin errors++; $error("FAIL D lane1 mul_sign"); end
    checks++;
    if (bus.mul_multiplicant !== 16'd5) begin errors++; $error("FAIL D lane1 multiplicant"); end
    @(negedge clk);
    checks++;
    if (bus.mul_sign !== 1'b1) begin errors++; $error("FAIL D lane2 mul_sign"); end
    checks++;
    if (bus.mul_multiplier !== 16'd8) begin errors++; $error("FAIL D lane2 multiplier"); end
    @(negedge clk);
    checks++;
    if (bus.result_valid !== 1'b1) begin errors++; $error("FAIL D result_valid"); end
    checks++;
    if (bus.result_product !== exp_res) begin errors++; $error("FAIL D result_product=%0h", bus.result_product); end
    mul_idle("D done");
    do_handshake("D", 32'd4);

    // E: flush during the third BUSY cycle
    for (int i = 0; i < 16; i++) begin
      mcand[16*i +: 16]  = 16'(i + 1);
      mplier[16*i +: 16] = 16'd2;
    end
    bus.start_valid = 1'b1;
    bus.op_mask = 16'hFFFF;
    bus.op_multiplicant = mcand;
    bus.op_multiplier = mplier;
    @(negedge clk);
    bus.start_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.mul_multiplicant !== 16'd3) begin errors++; $error("FAIL E third busy lane"); end
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    checks++;
    if (bus.start_ready !== 1'b1) begin errors++; $error("FAIL E flush start_ready"); end
    checks++;
    if (bus.result_valid !== 1'b0) begin errors++; $error("FAIL E flush result_valid"); end
    checks++;
    if (bus.ops_completed !== 32'd4) begin errors++; $error("FAIL E flush ops_completed"); end
    mul_idle("E flush");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (bus.result_valid !== 1'b0) begin errors++; $error("FAIL E post-flush result_valid"); end
    end

    // F: asynchronous reset between edges in the middle of BUSY
    bus.start_valid = 1'b1;
    @(negedge clk);
    bus.start_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.start_ready !== 1'b0) begin errors++; $error("FAIL F busy before reset"); end
    reset = 1'b1;
    #1;
    checks++;
    if (bus.start_ready !== 1'b1) begin errors++; $error("FAIL F rst start_ready"); end
    checks++;
    if (bus.result_product !== 512'd0) begin errors++; $error("FAIL F rst result_product"); end
    checks++;
    if (bus.ops_completed !== 32'd0) begin errors++; $error("FAIL F rst ops_completed"); end
    checks++;
    if (bus.result_valid !== 1'b0) begin errors++; $error("FAIL F rst result_valid"); end
    mul_idle("F rst");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
